// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the FIFO traffic scheduler.
// Stats outputs are built only when FIFO_SCHED_STATS_EN is defined.
package fifo_sched_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BURST,
        ST_GAP,
        ST_DRAIN,
        ST_DONE
    } wr_state_e;

    // Occupancy must hold the full-FIFO value 2^depth_w, hence one extra bit.
    function automatic int occ_width(input int depth_w);
        return depth_w + 1;
    endfunction

endpackage

// File: rtl/fifo_traffic_sched_rd_pacer.sv
// Read pacer: fires one read attempt every period+1 active cycles, or every cycle while draining.
// The rd_stall counter exists only when FIFO_SCHED_STATS_EN is defined.
module rd_pacer
    import fifo_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    input  logic             pace_en,
    input  logic             drain,
    input  logic             rd_rdy,
    output logic             re,
    output logic [CNT_W-1:0] rd_stall
);

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = pace_en && (tick_cnt == '0);
    assign re   = (tick || drain) && rd_rdy;

    // Counter starts at zero so the first paced cycle of a run is a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (clr) begin
            tick_cnt <= '0;
        end else if (pace_en) begin
            tick_cnt <= tick ? period : tick_cnt - 1'b1;
        end
    end

`ifdef FIFO_SCHED_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_stall <= '0;
        end else if (clr) begin
            rd_stall <= '0;
        end else if (tick && !rd_rdy) begin
            rd_stall <= sat_inc(rd_stall);
        end
    end
`else
    assign rd_stall = '0;
`endif

endmodule

// File: rtl/fifo_traffic_sched.sv
// Burst/gap write scheduler with paced reads and occupancy tracking for a circ_fifo.
// Define FIFO_SCHED_STATS_EN to build max_occ_o, wr_stall_o and rd_stall_o.
module fifo_traffic_sched
    import fifo_sched_pkg::*;
#(
    parameter int FIFO_DEPTH_W = 2,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      burst_len_i,
    input  logic [CNT_W-1:0]      idle_len_i,
    input  logic [CNT_W-1:0]      num_bursts_i,
    input  logic [CNT_W-1:0]      rd_period_i,
    input  logic                  wr_rdy_i,
    input  logic                  rd_rdy_i,
    output logic                  we_o,
    output logic                  re_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [FIFO_DEPTH_W:0] occupancy_o,
    output logic [FIFO_DEPTH_W:0] max_occ_o,
    output logic [CNT_W-1:0]      wr_stall_o,
    output logic [CNT_W-1:0]      rd_stall_o
);

    localparam int OCC_W = occ_width(FIFO_DEPTH_W);
    localparam logic [OCC_W-1:0] OCC_FULL = {1'b1, {FIFO_DEPTH_W{1'b0}}};

    wr_state_e        state;
    logic [CNT_W-1:0] burst_len_q;
    logic [CNT_W-1:0] idle_len_q;
    logic [CNT_W-1:0] rd_period_q;
    logic [CNT_W-1:0] bursts_left;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] idle_cnt;
    logic [OCC_W-1:0] occ_next;
    logic             start_ok;
    logic             last_beat;

    assign start_ok  = start_i && (state == ST_IDLE);
    assign we_o      = (state == ST_BURST) && wr_rdy_i;
    assign last_beat = we_o && (beat_cnt == burst_len_q - 1'b1);

    always_comb begin
        occ_next = occupancy_o;
        if (we_o && !re_o && occupancy_o != OCC_FULL) begin
            occ_next = occupancy_o + 1'b1;
        end else if (re_o && !we_o && occupancy_o != '0) begin
            occ_next = occupancy_o - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            occupancy_o <= '0;
            burst_len_q <= '0;
            idle_len_q  <= '0;
            rd_period_q <= '0;
            bursts_left <= '0;
            beat_cnt    <= '0;
            idle_cnt    <= '0;
        end else begin
            done_o      <= 1'b0;
            occupancy_o <= occ_next;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        burst_len_q <= (burst_len_i == '0) ? CNT_W'(1) : burst_len_i;
                        idle_len_q  <= idle_len_i;
                        rd_period_q <= rd_period_i;
                        bursts_left <= num_bursts_i;
                        beat_cnt    <= '0;
                        busy_o      <= 1'b1;
                        if (num_bursts_i == '0) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    if (last_beat) begin
                        beat_cnt    <= '0;
                        bursts_left <= bursts_left - 1'b1;
                        if (bursts_left > CNT_W'(1)) begin
                            if (idle_len_q != '0) begin
                                state    <= ST_GAP;
                                idle_cnt <= idle_len_q - 1'b1;
                            end
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (we_o) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (idle_cnt == '0) begin
                        state <= ST_BURST;
                    end else begin
                        idle_cnt <= idle_cnt - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (occupancy_o == '0) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    rd_pacer #(.CNT_W(CNT_W)) u_rd_pacer (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .clr      (start_ok),
        .period   (rd_period_q),
        .pace_en  ((state == ST_BURST) || (state == ST_GAP)),
        .drain    (state == ST_DRAIN),
        .rd_rdy   (rd_rdy_i),
        .re       (re_o),
        .rd_stall (rd_stall_o)
    );

`ifdef FIFO_SCHED_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [OCC_W-1:0] occ_max(input logic [OCC_W-1:0] a,
                                                input logic [OCC_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            max_occ_o  <= '0;
            wr_stall_o <= '0;
        end else if (start_ok) begin
            max_occ_o  <= '0;
            wr_stall_o <= '0;
        end else if (state != ST_IDLE) begin
            max_occ_o <= occ_max(max_occ_o, occ_next);
            if (state == ST_BURST && !wr_rdy_i) begin
                wr_stall_o <= sat_inc(wr_stall_o);
            end
        end
    end
`else
    assign max_occ_o  = '0;
    assign wr_stall_o = '0;
`endif

endmodule

// File: tb/tb_fifo_traffic_sched.sv
// Randomized bench for fifo_traffic_sched with a depth-4 FIFO environment and a transaction-level reference.
// Stats expectations follow FIFO_SCHED_STATS_EN.
module tb_fifo_traffic_sched;

    localparam int DEPTH_W = 2;
    localparam int DEPTH   = 4;
    localparam int CW      = 16;
    localparam int OW      = DEPTH_W + 1;

    localparam int P_IDLE  = 0;
    localparam int P_BURST = 1;
    localparam int P_GAP   = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [CW-1:0] burst_len_i = '0;
    logic [CW-1:0] idle_len_i = '0;
    logic [CW-1:0] num_bursts_i = '0;
    logic [CW-1:0] rd_period_i = '0;
    logic          wr_rdy_i = 1'b1;
    logic          rd_rdy_i = 1'b0;
    logic          we_o, re_o, busy_o, done_o;
    logic [OW-1:0] occupancy_o, max_occ_o;
    logic [CW-1:0] wr_stall_o, rd_stall_o;

    int checks = 0;
    int failures = 0;

    // reference run state
    int m_ph, m_beats, m_bdone, m_gap, m_tick, m_occ, m_max, m_wst, m_rst;
    bit m_busy, m_done;
    int c_b, c_i, c_n, c_p;
    int fcnt;
    int n_wr, n_re, n_done, n_busy, n_sim2;

    fifo_traffic_sched #(.FIFO_DEPTH_W(DEPTH_W), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .burst_len_i  (burst_len_i),
        .idle_len_i   (idle_len_i),
        .num_bursts_i (num_bursts_i),
        .rd_period_i  (rd_period_i),
        .wr_rdy_i     (wr_rdy_i),
        .rd_rdy_i     (rd_rdy_i),
        .we_o         (we_o),
        .re_o         (re_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .occupancy_o  (occupancy_o),
        .max_occ_o    (max_occ_o),
        .wr_stall_o   (wr_stall_o),
        .rd_stall_o   (rd_stall_o)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_ph = P_IDLE; m_beats = 0; m_bdone = 0; m_gap = 0; m_tick = 0;
        m_occ = 0; m_max = 0; m_wst = 0; m_rst = 0; m_busy = 0; m_done = 0;
        fcnt = 0;
    endtask

    // One clock: drive, compare registered and combinational outputs, advance the reference.
    task automatic step(input bit st, input int thr);
        bit wanted, tick, we_x, re_x;
        int occ_n, beff;
        logic [OW-1:0] e_max;
        logic [CW-1:0] e_wst, e_rst;
        @(negedge clk);
        start_i  = st;
        wr_rdy_i = (fcnt < DEPTH) && ($urandom_range(0, 99) >= thr);
        rd_rdy_i = (fcnt > 0);
        #1;
`ifdef FIFO_SCHED_STATS_EN
        e_max = OW'(m_max); e_wst = CW'(m_wst); e_rst = CW'(m_rst);
`else
        e_max = '0; e_wst = '0; e_rst = '0;
`endif
        checks++;
        if (busy_o !== m_busy) begin failures++; $display("FAIL busy got=%b exp=%b t=%0t", busy_o, m_busy, $time); end
        checks++;
        if (done_o !== m_done) begin failures++; $display("FAIL done got=%b exp=%b t=%0t", done_o, m_done, $time); end
        checks++;
        if (occupancy_o !== OW'(m_occ)) begin failures++; $display("FAIL occupancy got=%0d exp=%0d t=%0t", occupancy_o, m_occ, $time); end
        checks++;
        if (max_occ_o !== e_max) begin failures++; $display("FAIL max_occ got=%0d exp=%0d t=%0t", max_occ_o, e_max, $time); end
        checks++;
        if (wr_stall_o !== e_wst) begin failures++; $display("FAIL wr_stall got=%0d exp=%0d t=%0t", wr_stall_o, e_wst, $time); end
        checks++;
        if (rd_stall_o !== e_rst) begin failures++; $display("FAIL rd_stall got=%0d exp=%0d t=%0t", rd_stall_o, e_rst, $time); end

        wanted = (m_ph == P_BURST);
        tick   = (m_ph == P_BURST || m_ph == P_GAP) && (m_tick % (c_p + 1) == 0);
        we_x   = wanted && wr_rdy_i;
        re_x   = (tick || m_ph == P_DRAIN) && rd_rdy_i;
        checks++;
        if (we_o !== we_x) begin failures++; $display("FAIL we got=%b exp=%b t=%0t", we_o, we_x, $time); end
        checks++;
        if (re_o !== re_x) begin failures++; $display("FAIL re got=%b exp=%b t=%0t", re_o, re_x, $time); end

        n_wr += int'(we_o); n_re += int'(re_o); n_done += int'(done_o); n_busy += int'(busy_o);
        if (we_o && re_o && fcnt == 2) n_sim2++;

        if (wanted && !wr_rdy_i) m_wst++;
        if (tick && !rd_rdy_i) m_rst++;
        occ_n = m_occ;
        if (we_x && !re_x && m_occ < DEPTH) occ_n = m_occ + 1;
        if (re_x && !we_x && m_occ > 0) occ_n = m_occ - 1;
        if (m_ph != P_IDLE && occ_n > m_max) m_max = occ_n;
        beff = (c_b == 0) ? 1 : c_b;
        case (m_ph)
            P_IDLE: if (st) begin
                m_wst = 0; m_rst = 0; m_max = 0; m_beats = 0; m_bdone = 0; m_tick = 0;
                m_ph = (c_n == 0) ? P_DONE : P_BURST;
            end
            P_BURST: begin
                m_tick++;
                if (we_x) begin
                    m_beats++;
                    if (m_beats == beff) begin
                        m_beats = 0; m_bdone++;
                        if (m_bdone < c_n) begin
                            if (c_i > 0) begin m_ph = P_GAP; m_gap = c_i; end
                        end else m_ph = P_DRAIN;
                    end
                end
            end
            P_GAP: begin
                m_tick++; m_gap--;
                if (m_gap == 0) m_ph = P_BURST;
            end
            P_DRAIN: if (m_occ == 0) m_ph = P_DONE;
            default: m_ph = P_IDLE;
        endcase
        m_occ  = occ_n;
        m_busy = (m_ph != P_IDLE);
        m_done = (m_ph == P_DONE);

        if (we_o && !re_o && fcnt < DEPTH) fcnt++;
        else if (re_o && !we_o && fcnt > 0) fcnt--;
    endtask

    task automatic run_cfg(input int b, input int i, input int n, input int p, input int thr);
        int cyc;
        burst_len_i = CW'(b); idle_len_i = CW'(i); num_bursts_i = CW'(n); rd_period_i = CW'(p);
        c_b = b; c_i = i; c_n = n; c_p = p;
        n_wr = 0; n_re = 0; n_done = 0; n_busy = 0; n_sim2 = 0;
        step(1'b1, thr);
        cyc = 0;
        while (m_ph != P_IDLE && cyc < 2000) begin
            step(1'b0, thr);
            cyc++;
        end
        checks++;
        if (cyc >= 2000) begin failures++; $display("FAIL run_timeout cycles=%0d limit=2000", cyc); end
        step(1'b0, thr);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({we_o, re_o, busy_o, done_o} !== 4'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=0000", {we_o, re_o, busy_o, done_o}); end
        checks++;
        if ({occupancy_o, max_occ_o, wr_stall_o, rd_stall_o} !== '0) begin failures++; $display("FAIL reset_stats got=%h exp=0", {occupancy_o, max_occ_o, wr_stall_o, rd_stall_o}); end
        model_clear();
        rst_ni = 1'b1;
        step(1'b0, 0);
    endtask

    task automatic test_paced_bursts();
        run_cfg(3, 2, 2, 0, 0);
        checks++;
        if (n_wr != 6) begin failures++; $display("FAIL paced_writes got=%0d exp=6", n_wr); end
        checks++;
        if (wr_stall_o !== '0) begin failures++; $display("FAIL paced_wr_stall got=%0d exp=0", wr_stall_o); end
        checks++;
        if (max_occ_o > 1) begin failures++; $display("FAIL paced_max_occ got=%0d exp<=1", max_occ_o); end
        checks++;
        if (n_done != 1) begin failures++; $display("FAIL paced_done got=%0d exp=1", n_done); end
    endtask

    task automatic test_full_stall();
        run_cfg(8, 0, 1, 3, 0);
        checks++;
        if (n_wr != 8) begin failures++; $display("FAIL stall_writes got=%0d exp=8", n_wr); end
        checks++;
        if (n_done != 1) begin failures++; $display("FAIL stall_done got=%0d exp=1", n_done); end
        checks++;
        if (occupancy_o !== '0) begin failures++; $display("FAIL stall_drained got=%0d exp=0", occupancy_o); end
`ifdef FIFO_SCHED_STATS_EN
        checks++;
        if (max_occ_o !== OW'(4)) begin failures++; $display("FAIL stall_max_occ got=%0d exp=4", max_occ_o); end
        checks++;
        if (wr_stall_o == '0) begin failures++; $display("FAIL stall_wr_stall got=%0d exp>0", wr_stall_o); end
`else
        checks++;
        if ({max_occ_o, wr_stall_o, rd_stall_o} !== '0) begin failures++; $display("FAIL stall_stats_off got=%h exp=0", {max_occ_o, wr_stall_o, rd_stall_o}); end
`endif
    endtask

    task automatic test_zero_bursts();
        run_cfg(4, 1, 0, 0, 0);
        checks++;
        if (n_busy != 1) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=1", n_busy); end
        checks++;
        if (n_done != 1) begin failures++; $display("FAIL zero_done got=%0d exp=1", n_done); end
        checks++;
        if (n_wr + n_re != 0) begin failures++; $display("FAIL zero_transfers got=%0d exp=0", n_wr + n_re); end
    endtask

    task automatic test_simultaneous();
        run_cfg(6, 0, 1, 1, 0);
        checks++;
        if (n_sim2 == 0) begin failures++; $display("FAIL simul_at_2 got=%0d exp>0", n_sim2); end
        checks++;
        if (n_wr != 6) begin failures++; $display("FAIL simul_writes got=%0d exp=6", n_wr); end
    endtask

    task automatic test_reset_mid_burst();
        burst_len_i = 16'd10; idle_len_i = 16'd0; num_bursts_i = 16'd2; rd_period_i = 16'd2;
        c_b = 10; c_i = 0; c_n = 2; c_p = 2;
        n_done = 0;
        step(1'b1, 0);
        repeat (3) step(1'b0, 0);
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({we_o, re_o, busy_o, done_o} !== 4'b0) begin failures++; $display("FAIL midrst_ctl got=%b exp=0000", {we_o, re_o, busy_o, done_o}); end
        checks++;
        if ({occupancy_o, max_occ_o, wr_stall_o, rd_stall_o} !== '0) begin failures++; $display("FAIL midrst_stats got=%h exp=0", {occupancy_o, max_occ_o, wr_stall_o, rd_stall_o}); end
        checks++;
        if (n_done != 0) begin failures++; $display("FAIL midrst_done got=%0d exp=0", n_done); end
        model_clear();
        @(negedge clk);
        rst_ni = 1'b1;
        run_cfg(2, 1, 2, 0, 0);
        checks++;
        if (n_wr != 4 || n_done != 1) begin failures++; $display("FAIL midrst_rerun got=%0d/%0d exp=4/1", n_wr, n_done); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            int b, i, n, p, thr;
            b = $urandom_range(0, 5); i = $urandom_range(0, 3); n = $urandom_range(0, 3);
            p = $urandom_range(0, 4); thr = $urandom_range(0, 40);
            run_cfg(b, i, n, p, thr);
            checks++;
            if (n_wr != ((b == 0) ? 1 : b) * n) begin failures++; $display("FAIL rand_writes cfg=%0d/%0d/%0d/%0d got=%0d exp=%0d", b, i, n, p, n_wr, ((b == 0) ? 1 : b) * n); end
            checks++;
            if (n_done != 1) begin failures++; $display("FAIL rand_done got=%0d exp=1", n_done); end
        end
    endtask

    initial begin
        model_clear();
        c_b = 1; c_i = 0; c_n = 0; c_p = 0;
        n_wr = 0; n_re = 0; n_done = 0; n_busy = 0; n_sim2 = 0;
        test_reset();
        test_paced_bursts();
        test_full_stall();
        test_zero_bursts();
        test_simultaneous();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_traffic_sched.md
# fifo_traffic_sched

Single-clock traffic scheduler that sequences the write and read enables of a synchronous `circ_fifo` for buffer-throughput measurement. It generates programmable write bursts separated by idle gaps and paces reads at a fixed period, always honouring the FIFO's ready flags. It tracks occupancy, a high-water mark and stall counts, so a bench can size `FIFO_DEPTH_W` for a given traffic profile. It sits between the test controller and the FIFO, replacing free-running `we`/`re` stimulus.

## Interface
- `FIFO_DEPTH_W`, 2, log2 of FIFO depth; occupancy width is `FIFO_DEPTH_W+1`.
- `CNT_W`, 16, width of config fields and stall counters.
- `clk_i  in  1`  clock; shared with the FIFO.
- `rst_ni  in  1`  reset; one clock, asynchronous active-low reset.
- `start_i  in  1`  one-cycle pulse that latches the config and starts a run; ignored while `busy_o`.
- `burst_len_i  in  CNT_W`  accepted writes per burst; 0 is treated as 1.
- `idle_len_i  in  CNT_W`  idle cycles between bursts; 0 means no gap.
- `num_bursts_i  in  CNT_W`  bursts per run; 0 means an immediate done.
- `rd_period_i  in  CNT_W`  one read attempt every `rd_period_i+1` cycles.
- `wr_rdy_i  in  1`  FIFO not full.
- `rd_rdy_i  in  1`  FIFO not empty.
- `we_o  out  1`  FIFO write enable.
- `re_o  out  1`  FIFO read enable.
- `busy_o  out  1`  run in progress.
- `done_o  out  1`  one-cycle end-of-run pulse.
- `occupancy_o  out  FIFO_DEPTH_W+1`  tracked FIFO fill level.
- `max_occ_o  out  FIFO_DEPTH_W+1`  high-water mark for the run.
- `wr_stall_o  out  CNT_W`  count of cycles where a write was wanted but `wr_rdy_i` was 0.
- `rd_stall_o  out  CNT_W`  count of read-pace ticks where `rd_rdy_i` was 0.

## Operation
- **Write FSM states:** IDLE, BURST, GAP, DRAIN, DONE.
- **IDLE:**
  - On `start_i`, latch all config fields, clear counters and `max_occ_o`.
  - Go to BURST, or to DONE if `num_bursts_i==0`.
- **BURST:**
  - `we_o = wr_rdy_i`, combinational, so the block never writes into a full FIFO.
  - The beat counter advances only on an accepted write (`we_o & wr_rdy_i`).
  - After the last beat: go to GAP if bursts remain and `idle_len>0`; go to BURST if bursts remain and `idle_len==0`; otherwise go to DRAIN.
- **GAP:** `we_o=0`; count `idle_len` cycles, then go to BURST.
- **DRAIN:** `we_o=0`; the read pacer is overridden and reads every cycle; exit to DONE when `occupancy==0`.
- **DONE:** `done_o=1` for one cycle, `busy_o` drops, go to IDLE.
- **Read pacer (BURST/GAP):**
  - A tick counter reloads with `rd_period` and fires at 0.
  - On a tick, `re_o = rd_rdy_i`.
  - A tick with `rd_rdy_i=0` increments `rd_stall` and is lost, not deferred.
- **Occupancy:**
  - +1 on accepted write, −1 on accepted read, unchanged when both occur.
  - Saturates at 0 and at 2^FIFO_DEPTH_W; never wraps.
- **Max occupancy:** `max_occ <= max(max_occ, next occupancy)`.
- **Stall counters:** saturate at all-ones.
- **Reset:** all outputs and state are 0 / IDLE. A reset mid-run aborts without `done_o`.

## Timing
- `we_o` and `re_o` are combinational from state and ready inputs, giving zero-cycle handshake. All other outputs are registered.
- First `we_o` can assert the cycle after `start_i`.
- BURST→GAP→BURST: exactly `idle_len` cycles with `we_o=0` when `wr_rdy_i` stays 1.
- A stalled write holds BURST; the beat count does not advance.
- `done_o` asserts one cycle after occupancy reaches 0 in DRAIN.
- `occupancy_o` and `max_occ_o` reflect accepted transfers one cycle later.

## Configuration
- `FIFO_SCHED_STATS_EN`:
  - **Defined:** `max_occ_o`, `wr_stall_o` and `rd_stall_o` are implemented as above.
  - **Undefined:** these outputs are tied to 0 and their registers are removed; scheduling and occupancy tracking are unchanged.

## Structure
- Package `fifo_sched_pkg` holds:
  - the write FSM state enum;
  - `CNT_W` default;
  - the occupancy-width helper constant.
- One sub-module, `rd_pacer`: period counter, tick generation and `rd_stall` counting.

## Test plan
- Depth 4; burst=3, idle=2, bursts=2, rd_period=0 → six writes, zero `wr_stall`, `max_occ<=1`, `done_o` once.
- Depth 4; burst=8, bursts=1, rd_period=3 → writes stall at occupancy 4, `wr_stall>0`, `max_occ=4`; DRAIN empties the FIFO, then `done_o`.
- `num_bursts=0` → `busy_o` for one cycle, `done_o` pulse, no `we_o`/`re_o`.
- Simultaneous accepted write and read at occupancy 2 → occupancy stays 2.
- `rst_ni` low mid-BURST → all outputs 0 immediately, no `done_o`; a new `start_i` runs cleanly.
- Without `FIFO_SCHED_STATS_EN`, repeat test 2 → stall and max outputs stay 0, `we_o`/`re_o` trace identical.
